rbm_input_loader: RTL
=====================

// Module: rbm_input_loader
// PURPOSE
// - Upstream feeder for the RBM layer. Accepts a serial pixel stream over a valid/ready handshake.
// - Binarises each pixel and packs INPUT_DIM fields into the layer's flat input vector.
// - Per vector: pulses the layer restart, holds data_valid until the layer reports finish, then loads the next sample.
// PARAMETERS
// - BITLENGTH        12       width of each packed field (matches layer bitlength)
// - PIXEL_BITLENGTH  8        width of incoming pixel
// - INPUT_DIM        15       fields per vector (layer input_dim)
// - THRESHOLD        128      deterministic binarisation threshold, PIXEL_BITLENGTH wide
// - LFSR_SEED        16'hACE1 LFSR reset value (stochastic mode only); must be non-zero
// PORTS
// - clock          in   1                      system clock, posedge
// - reset          in   1                      asynchronous, active-high
// - pix_valid      in   1                      pixel present
// - pix_data       in   PIXEL_BITLENGTH        unsigned pixel
// - pix_last       in   1                      sender marks last pixel of vector
// - pix_ready      out  1                      loader accepts pixel this cycle
// - layer_restart  out  1                      1-cycle pulse; drives layer reset
// - layer_valid    out  1                      drives layer data_valid
// - layer_data     out  INPUT_DIM*BITLENGTH    field k at [k*BITLENGTH +: BITLENGTH]
// - layer_finish   in   1                      layer finish
// - sample_done    out  1                      1-cycle pulse per consumed vector
// - sample_count   out  16                     consumed vectors, wraps 16'hFFFF->0
// - frame_err      out  1                      sticky pix_last mismatch flag
// BEHAVIOUR
// - Reset (async, any state): state=LOAD, index=0, LFSR=LFSR_SEED; all outputs 0 except pix_ready=1 after release.
// - FSM LOAD:
//   - pix_ready=1, layer_valid=0.
//   - A pixel is accepted when pix_valid & pix_ready.
//   - Accepted pixel writes field[index] = {BITLENGTH-1 zeros, bit}; index++.
// - FSM RESTART: exactly 1 cycle.
//   - Entered the cycle after the pixel at index INPUT_DIM-1 is accepted.
//   - layer_restart=1, pix_ready=0, layer_valid=0, index=0.
// - FSM PRESENT:
//   - layer_valid=1, pix_ready=0.
//   - layer_data is held stable for the whole state.
//   - When layer_finish=1: next cycle state=LOAD, layer_valid=0, sample_done=1, sample_count++.
// - Latency: last pixel accepted at cycle N -> layer_restart at N+1 -> layer_valid at N+2.
// - Minimum one PRESENT cycle before finish is honoured.
// - layer_finish is ignored in LOAD and RESTART.
// - Deterministic bit = (pix_data >= THRESHOLD).
// - pix_last checking:
//   - pix_last=1 accepted at index < INPUT_DIM-1: set frame_err, discard the partial vector (index=0), stay in LOAD.
//   - pix_last=0 at index INPUT_DIM-1: set frame_err; the vector still completes.
//   - frame_err clears only on reset.
// - No pixel is accepted outside LOAD. pix_valid held high during RESTART/PRESENT is accepted on the first LOAD cycle.
// - Reset mid-PRESENT drops layer_valid asynchronously and discards the vector. sample_count=0.
// CONFIGURATION
// - RBM_LOADER_STOCHASTIC_EN defined:
//   - 16-bit Fibonacci LFSR, taps 16,14,13,11, seeded LFSR_SEED.
//   - bit = (pix_data > lfsr[PIXEL_BITLENGTH-1:0]).
//   - LFSR advances once per accepted pixel only.
//   - THRESHOLD is unused.
// - RBM_LOADER_STOCHASTIC_EN undefined: deterministic threshold; no LFSR logic synthesised.
// TESTING
// - Defaults, deterministic: pixels 0,127,128,255 repeated to 15, pix_last on 15th.
//   -> fields 0,0,1,1,... ; restart at N+1; valid at N+2; frame_err=0.
// - pix_valid toggled 1/0 every cycle during load.
//   -> exactly 15 accepts; vector identical to the gap-free case; pix_ready=0 from RESTART until sample_done+0.
// - Early pix_last on 6th pixel (index 5).
//   -> frame_err=1; no layer_restart; next full 15-pixel vector presents correctly.
// - layer_finish forced 1 during LOAD and RESTART.
//   -> no sample_done; in PRESENT, finish at cycle P -> layer_valid=0 and sample_done=1 at P+1; sample_count=1.
// - Assert reset 3 cycles into PRESENT.
//   -> layer_valid=0 and sample_count=0 immediately; after release, pix_ready=1 and index restarts at 0.
// - STOCHASTIC_EN: 15 pixels of 0 -> all fields 0; 1000 pixels of 128 -> ones fraction 0.45-0.55;
//   repeat after reset -> bit-identical vectors.

Source files
------------

// File: rtl/rbm_input_loader_if.sv
// -----------------------------------------------------------------------------
// rbm_input_loader_if
// Serial pixel stream between a pixel source and the RBM input loader.
//   pix_valid  source -> loader   pixel present
//   pix_data   source -> loader   unsigned pixel, PIXEL_BITLENGTH wide
//   pix_last   source -> loader   last pixel of a vector
//   pix_ready  loader -> source   loader accepts the pixel this cycle
// Modports: master (pixel source), slave (loader).
// -----------------------------------------------------------------------------
interface rbm_input_loader_if #(
   parameter int PIXEL_BITLENGTH = 8
);
   logic                       pix_valid;
   logic [PIXEL_BITLENGTH-1:0] pix_data;
   logic                       pix_last;
   logic                       pix_ready;

   modport master (output pix_valid, output pix_data, output pix_last, input pix_ready);
   modport slave  (input pix_valid, input pix_data, input pix_last, output pix_ready);
endinterface

// File: rtl/rbm_input_loader.sv
// -----------------------------------------------------------------------------
// rbm_input_loader
// Upstream feeder for the RBM layer. Accepts a serial pixel stream, binarises
// each pixel and packs INPUT_DIM one-bit fields (zero-extended to BITLENGTH)
// into the layer's flat input vector. Per vector it pulses layer_restart, holds
// layer_valid until layer_finish, then returns to loading.
//
// Ports:
//   clock, reset     system clock (posedge), asynchronous active-high reset
//   pix              pixel stream (rbm_input_loader_if.slave)
//   layer_restart    1-cycle pulse driving the layer reset
//   layer_valid      layer data_valid
//   layer_data       field k at [k*BITLENGTH +: BITLENGTH]
//   layer_finish     layer finish
//   sample_done      1-cycle pulse per consumed vector
//   sample_count     consumed vectors, wraps at 16 bits
//   frame_err        sticky pix_last framing error
//
// Build option: RBM_LOADER_STOCHASTIC_EN selects stochastic binarisation
// against a 16-bit Fibonacci LFSR (taps 16,14,13,11); without it a fixed
// THRESHOLD compare is used and no LFSR exists.
//
// state   | meaning
// LOAD    | accepting pixels, filling field[index]
// RESTART | one-cycle layer_restart pulse, vector complete
// PRESENT | layer_valid high, data held until layer_finish
// -----------------------------------------------------------------------------
module rbm_input_loader #(
   parameter int          BITLENGTH       = 12,
   parameter int          PIXEL_BITLENGTH = 8,
   parameter int          INPUT_DIM       = 15,
   parameter int          THRESHOLD       = 128,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic                           clock,
   input  logic                           reset,
   rbm_input_loader_if.slave              pix,
   output logic                           layer_restart,
   output logic                           layer_valid,
   output logic [INPUT_DIM*BITLENGTH-1:0] layer_data,
   input  logic                           layer_finish,
   output logic                           sample_done,
   output logic [15:0]                    sample_count,
   output logic                           frame_err
);
   localparam int IDX_W = (INPUT_DIM > 1) ? $clog2(INPUT_DIM) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_DIM - 1);

   if (LFSR_SEED == 16'h0000) begin : g_bad_seed
      $error("rbm_input_loader: LFSR_SEED must be non-zero");
   end

   typedef enum logic [1:0] {LOAD, RESTART, PRESENT} state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     index_q, index_d;
   logic [INPUT_DIM-1:0] bits_q, bits_d;
   logic                 frame_err_q, frame_err_d;
   logic                 sample_done_q, sample_done_d;
   logic [15:0]          sample_count_q, sample_count_d;
   logic                 accept;
   logic                 pix_bit;

   // Ready is held low while reset is asserted, high in LOAD otherwise.
   assign pix.pix_ready = (state_q == LOAD) && !reset;
   assign accept        = pix.pix_valid && pix.pix_ready;

`ifdef RBM_LOADER_STOCHASTIC_EN
   logic [15:0] lfsr_q, lfsr_d;
   assign pix_bit = pix.pix_data > lfsr_q[PIXEL_BITLENGTH-1:0];

   always_comb begin
      lfsr_d = lfsr_q;
      if (accept) begin
         lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   localparam logic [PIXEL_BITLENGTH-1:0] THRESH = PIXEL_BITLENGTH'(THRESHOLD);
   assign pix_bit = pix.pix_data >= THRESH;
`endif

   always_comb begin
      state_d        = state_q;
      index_d        = index_q;
      bits_d         = bits_q;
      frame_err_d    = frame_err_q;
      sample_done_d  = 1'b0;
      sample_count_d = sample_count_q;
      case (state_q)
         LOAD: begin
            if (accept) begin
               bits_d[index_q] = pix_bit;
               if (index_q == LAST_IDX) begin
                  index_d = '0;
                  state_d = RESTART;
                  if (!pix.pix_last) frame_err_d = 1'b1;
               end else if (pix.pix_last) begin
                  // Early end of frame: drop the partial vector and restart filling.
                  index_d     = '0;
                  frame_err_d = 1'b1;
               end else begin
                  index_d = index_q + 1'b1;
               end
            end
         end
         RESTART: begin
            index_d = '0;
            state_d = PRESENT;
         end
         PRESENT: begin
            if (layer_finish) begin
               state_d        = LOAD;
               sample_done_d  = 1'b1;
               sample_count_d = sample_count_q + 16'd1;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= LOAD;
         index_q        <= '0;
         bits_q         <= '0;
         frame_err_q    <= 1'b0;
         sample_done_q  <= 1'b0;
         sample_count_q <= 16'd0;
      end else begin
         state_q        <= state_d;
         index_q        <= index_d;
         bits_q         <= bits_d;
         frame_err_q    <= frame_err_d;
         sample_done_q  <= sample_done_d;
         sample_count_q <= sample_count_d;
      end
   end

   for (genvar k = 0; k < INPUT_DIM; k++) begin : g_field
      if (BITLENGTH > 1) begin : g_pad
         assign layer_data[k*BITLENGTH +: BITLENGTH] = {{(BITLENGTH-1){1'b0}}, bits_q[k]};
      end else begin : g_nopad
         assign layer_data[k] = bits_q[k];
      end
   end

   assign layer_restart = (state_q == RESTART);
   assign layer_valid   = (state_q == PRESENT);
   assign sample_done   = sample_done_q;
   assign sample_count  = sample_count_q;
   assign frame_err     = frame_err_q;
endmodule
